// File: rtl/bcd_press_counter_pkg.sv
// rtl/bcd_press_counter_pkg.sv - shared display constants and debouncer state encoding
package bcd_press_counter_pkg;

  localparam int         BCD_W                   = 4;
  localparam logic [3:0] BCD_MAX                 = 4'd9;
  localparam int         DEFAULT_DEBOUNCE_CYCLES = 65535;

  typedef enum logic [1:0] {
    DB_IDLE      = 2'd0,
    DB_ARMING    = 2'd1,
    DB_HELD      = 2'd2,
    DB_RELEASING = 2'd3
  } db_state_t;

endpackage

// File: rtl/bcd_press_counter_press_debouncer.sv
// rtl/bcd_press_counter_press_debouncer.sv - 2-flop synchronizer plus debounce FSM for one button
// Optional hold auto-repeat under BCD_PRESS_COUNTER_HOLD_REPEAT_EN.
module press_debouncer
  import bcd_press_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
`ifdef BCD_PRESS_COUNTER_HOLD_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic            sync_a;
  logic            sync_b;
  db_state_t       state;
  logic [CNT_W-1:0] stable_cnt;
  logic            entry;

  // Entry strobe is decoded from registered state so it lands in the accepting cycle.
  assign entry = (state == DB_ARMING) && sync_b && (stable_cnt == CNT_LAST);
  assign level = entry || (state == DB_HELD) || (state == DB_RELEASING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a     <= 1'b0;
      sync_b     <= 1'b0;
      state      <= DB_IDLE;
      stable_cnt <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      case (state)
        DB_IDLE: begin
          if (sync_b) begin
            state      <= DB_ARMING;
            stable_cnt <= '0;
          end
        end
        DB_ARMING: begin
          if (!sync_b) begin
            state      <= DB_IDLE;
            stable_cnt <= '0;
          end else if (entry) begin
            state      <= DB_HELD;
            stable_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end
        DB_HELD: begin
          if (!sync_b) begin
            state      <= DB_RELEASING;
            stable_cnt <= '0;
          end
        end
        default: begin
          if (sync_b) begin
            state      <= DB_HELD;
            stable_cnt <= '0;
          end else if (stable_cnt == CNT_LAST) begin
            state      <= DB_IDLE;
            stable_cnt <= '0;
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef BCD_PRESS_COUNTER_HOLD_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;

  logic [HOLD_W-1:0] hold_cnt;
  logic              repeating;
  logic [HOLD_W-1:0] hold_limit;
  logic              repeat_fire;

  // First step waits the long delay, later steps use the short period.
  assign hold_limit  = repeating ? HOLD_W'(REPEAT_PERIOD - 1) : HOLD_W'(REPEAT_DELAY - 1);
  assign repeat_fire = (state == DB_HELD) && (hold_cnt == hold_limit);
  assign press       = entry || repeat_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (state != DB_HELD) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (repeat_fire) begin
      hold_cnt  <= '0;
      repeating <= 1'b1;
    end else begin
      hold_cnt  <= hold_cnt + 1'b1;
    end
  end
`else
  assign press = entry;
`endif

endmodule

// File: rtl/bcd_press_counter.sv
// rtl/bcd_press_counter.sv - debounced inc/dec/clear buttons driving a cascaded BCD up/down counter
// Hold auto-repeat is built only when BCD_PRESS_COUNTER_HOLD_REPEAT_EN is defined.
module bcd_press_counter
  import bcd_press_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int DIGITS          = 4,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                    sysclock,
  input  logic                    reset,
  input  logic                    raw_inc,
  input  logic                    raw_dec,
  input  logic                    raw_clear,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    inc_pulse,
  output logic                    dec_pulse,
  output logic                    overflow,
  output logic                    underflow
);

  if (DEBOUNCE_CYCLES < 2 || DIGITS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("bcd_press_counter: illegal parameter value");
  end

  logic inc_press, inc_level;
  logic dec_press, dec_level;
  logic clear_press, clear_level;
  logic unused_levels;

  press_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BCD_PRESS_COUNTER_HOLD_REPEAT_EN
    , .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_inc (.clk(sysclock), .rst_n(reset), .raw(raw_inc), .press(inc_press), .level(inc_level));

  press_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BCD_PRESS_COUNTER_HOLD_REPEAT_EN
    , .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_dec (.clk(sysclock), .rst_n(reset), .raw(raw_dec), .press(dec_press), .level(dec_level));

  press_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BCD_PRESS_COUNTER_HOLD_REPEAT_EN
    , .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
  ) u_clear (.clk(sysclock), .rst_n(reset), .raw(raw_clear), .press(clear_press), .level(clear_level));

  assign unused_levels = inc_level ^ dec_level ^ clear_press;

  // Clear wins; coincident inc and dec cancel out entirely.
  logic apply_inc, apply_dec;
  assign apply_inc = inc_press && !dec_press && !clear_level;
  assign apply_dec = dec_press && !inc_press && !clear_level;

  logic [DIGITS:0]             carry;
  logic [DIGITS:0]             borrow;
  logic [BCD_W*DIGITS-1:0]     count_up;
  logic [BCD_W*DIGITS-1:0]     count_down;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [BCD_W-1:0] digit;
    assign digit = count[i*BCD_W +: BCD_W];
    assign count_up[i*BCD_W +: BCD_W] =
      !carry[i] ? digit : ((digit == BCD_MAX) ? '0 : digit + 1'b1);
    assign count_down[i*BCD_W +: BCD_W] =
      !borrow[i] ? digit : ((digit == '0) ? BCD_MAX : digit - 1'b1);
    assign carry[i+1]  = carry[i]  && (digit == BCD_MAX);
    assign borrow[i+1] = borrow[i] && (digit == '0);
  end

  always_ff @(posedge sysclock or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      inc_pulse <= apply_inc;
      dec_pulse <= apply_dec;
      overflow  <= apply_inc && carry[DIGITS];
      underflow <= apply_dec && borrow[DIGITS];
      if (clear_level) begin
        count <= '0;
      end else if (apply_inc) begin
        count <= count_up;
      end else if (apply_dec) begin
        count <= count_down;
      end
    end
  end

endmodule
